// File: rtl/rs_scheduler.sv
// Reservation-station bank for one functional unit: allocate on issue,
// wake operands from the CDB, and dispatch the lowest ready entry.
module rs_scheduler #(
  parameter int num_entries = 4,
  parameter int data_width  = 16,
  parameter int tag_width   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic [3:0]                    issue_op,
  input  logic [data_width-1:0]         issue_Vj,
  input  logic                          issue_Vj_valid,
  input  logic [tag_width-1:0]          issue_Qj,
  input  logic [data_width-1:0]         issue_Vk,
  input  logic                          issue_Vk_valid,
  input  logic [tag_width-1:0]          issue_Qk,
  input  logic [tag_width-1:0]          issue_dest,
  output logic                          full,
  input  logic                          cdb_valid,
  input  logic [tag_width-1:0]          cdb_tag,
  input  logic [data_width-1:0]         cdb_data,
  input  logic                          fu_ready,
  output logic                          disp_valid,
  output logic [3:0]                    disp_op,
  output logic [data_width-1:0]         disp_Vj,
  output logic [data_width-1:0]         disp_Vk,
  output logic [tag_width-1:0]          disp_dest,
  output logic [$clog2(num_entries):0]  occupancy
);

  localparam int idx_w = $clog2(num_entries);
  localparam int occ_w = idx_w + 1;

  typedef struct packed {
    logic                  busy;
    logic [3:0]            op;
    logic [data_width-1:0] vj;
    logic                  vj_valid;
    logic [tag_width-1:0]  qj;
    logic [data_width-1:0] vk;
    logic                  vk_valid;
    logic [tag_width-1:0]  qk;
    logic [tag_width-1:0]  dest;
  } ent_t;

  ent_t ent_q [num_entries];
  ent_t ent_d [num_entries];
  logic [occ_w-1:0] occ_q, occ_d;

  logic [num_entries-1:0] busy;
  logic [num_entries-1:0] ready;
  logic [idx_w-1:0]       alloc_idx;
  logic [idx_w-1:0]       sel_idx;
  logic                   alloc_ok;
  logic                   disp_fire;
  ent_t                   new_ent;
  ent_t                   sel_ent;

  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < num_entries; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy & ent_q[i].vj_valid & ent_q[i].vk_valid;
    end
  end

  assign full       = &busy;
  assign disp_valid = |ready;
  assign alloc_ok   = issue_valid & ~full;
  assign disp_fire  = disp_valid & fu_ready;

  // Descending scan so the lowest index wins
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    for (int i = num_entries - 1; i >= 0; i--) begin
      if (!busy[i])
        alloc_idx = idx_w'(i);
      if (ready[i])
        sel_idx = idx_w'(i);
    end
  end

  always_comb begin
    sel_ent = '0;
    if (disp_valid)
      sel_ent = ent_q[sel_idx];
  end

  assign disp_op   = sel_ent.op;
  assign disp_Vj   = sel_ent.vj;
  assign disp_Vk   = sel_ent.vk;
  assign disp_dest = sel_ent.dest;
  assign occupancy = occ_q;

  always_comb begin
    new_ent          = '0;
    new_ent.busy     = 1'b1;
    new_ent.op       = issue_op;
    new_ent.vj       = issue_Vj;
    new_ent.vj_valid = issue_Vj_valid;
    new_ent.qj       = issue_Qj;
    new_ent.vk       = issue_Vk;
    new_ent.vk_valid = issue_Vk_valid;
    new_ent.qk       = issue_Qk;
    new_ent.dest     = issue_dest;
    if (cdb_valid && !issue_Vj_valid && issue_Qj == cdb_tag) begin
      new_ent.vj       = cdb_data;
      new_ent.vj_valid = 1'b1;
    end
    if (cdb_valid && !issue_Vk_valid && issue_Qk == cdb_tag) begin
      new_ent.vk       = cdb_data;
      new_ent.vk_valid = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < num_entries; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid && ent_q[i].busy) begin
        if (!ent_q[i].vj_valid && ent_q[i].qj == cdb_tag) begin
          ent_d[i].vj       = cdb_data;
          ent_d[i].vj_valid = 1'b1;
        end
        if (!ent_q[i].vk_valid && ent_q[i].qk == cdb_tag) begin
          ent_d[i].vk       = cdb_data;
          ent_d[i].vk_valid = 1'b1;
        end
      end
    end
    // Alloc and dispatch never target the same slot: one is free, one busy
    if (disp_fire)
      ent_d[sel_idx] = '0;
    if (alloc_ok)
      ent_d[alloc_idx] = new_ent;
    if (flush) begin
      for (int i = 0; i < num_entries; i++)
        ent_d[i] = '0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({alloc_ok, disp_fire})
      2'b10:   occ_d = occ_q + occ_w'(1);
      2'b01:   occ_d = occ_q - occ_w'(1);
      default: occ_d = occ_q;
    endcase
    if (flush)
      occ_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < num_entries; i++)
        ent_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < num_entries; i++)
        ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed testbench for rs_scheduler: allocation, wakeup, bypass,
// backpressure, simultaneous issue/dispatch, flush and async reset.
module tb_rs_scheduler;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [15:0] issue_Vj;
  logic        issue_Vj_valid;
  logic [2:0]  issue_Qj;
  logic [15:0] issue_Vk;
  logic        issue_Vk_valid;
  logic [2:0]  issue_Qk;
  logic [2:0]  issue_dest;
  logic        full;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        fu_ready;
  logic        disp_valid;
  logic [3:0]  disp_op;
  logic [15:0] disp_Vj;
  logic [15:0] disp_Vk;
  logic [2:0]  disp_dest;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  rs_scheduler #(
    .num_entries(4),
    .data_width (16),
    .tag_width  (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_op      (issue_op),
    .issue_Vj      (issue_Vj),
    .issue_Vj_valid(issue_Vj_valid),
    .issue_Qj      (issue_Qj),
    .issue_Vk      (issue_Vk),
    .issue_Vk_valid(issue_Vk_valid),
    .issue_Qk      (issue_Qk),
    .issue_dest    (issue_dest),
    .full          (full),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .fu_ready      (fu_ready),
    .disp_valid    (disp_valid),
    .disp_op       (disp_op),
    .disp_Vj       (disp_Vj),
    .disp_Vk       (disp_Vk),
    .disp_dest     (disp_dest),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush          = 1'b0;
    issue_valid    = 1'b0;
    issue_op       = '0;
    issue_Vj       = '0;
    issue_Vj_valid = 1'b0;
    issue_Qj       = '0;
    issue_Vk       = '0;
    issue_Vk_valid = 1'b0;
    issue_Qk       = '0;
    issue_dest     = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_data       = '0;
  endtask

  task automatic drive_issue(input logic [3:0] op,
                             input logic [15:0] vj, input logic vjv,
                             input logic [2:0] qj,
                             input logic [15:0] vk, input logic vkv,
                             input logic [2:0] qk,
                             input logic [2:0] dest);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_Vj       = vj;
    issue_Vj_valid = vjv;
    issue_Qj       = qj;
    issue_Vk       = vk;
    issue_Vk_valid = vkv;
    issue_Qk       = qk;
    issue_dest     = dest;
  endtask

  task automatic test_reset();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", full); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0h want 0", disp_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if ({disp_op, disp_Vj, disp_Vk, disp_dest} !== 39'd0) begin errors++; $display("FAIL reset_disp: got %0h want 0", {disp_op, disp_Vj, disp_Vk, disp_dest}); end
  endtask

  task automatic test_ready_issue();
    fu_ready = 1'b1;
    drive_issue(4'b0001, 16'd5, 1'b1, 3'd0, 16'd7, 1'b1, 3'd0, 3'd2);
    tick();
    idle();
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL ready_dv: got %0h want 1", disp_valid); end
    checks++; if (disp_op !== 4'b0001) begin errors++; $display("FAIL ready_op: got %0h want 1", disp_op); end
    checks++; if (disp_Vj !== 16'd5) begin errors++; $display("FAIL ready_vj: got %0d want 5", disp_Vj); end
    checks++; if (disp_Vk !== 16'd7) begin errors++; $display("FAIL ready_vk: got %0d want 7", disp_Vk); end
    checks++; if (disp_dest !== 3'd2) begin errors++; $display("FAIL ready_dest: got %0d want 2", disp_dest); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL ready_occ1: got %0d want 1", occupancy); end
    tick();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL ready_occ0: got %0d want 0", occupancy); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL ready_dv0: got %0h want 0", disp_valid); end
  endtask

  task automatic test_wakeup();
    fu_ready = 1'b1;
    drive_issue(4'b0101, 16'd0, 1'b0, 3'd4, 16'd3, 1'b1, 3'd0, 3'd1);
    tick();
    idle();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wake_pending: got %0h want 0", disp_valid); end
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0055;
    tick();
    idle();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag: got %0h want 0", disp_valid); end
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h00AA;
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle: got %0h want 0", disp_valid); end
    tick();
    idle();
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL wake_dv: got %0h want 1", disp_valid); end
    checks++; if (disp_Vj !== 16'h00AA) begin errors++; $display("FAIL wake_vj: got %0h want 00aa", disp_Vj); end
    checks++; if (disp_Vk !== 16'd3) begin errors++; $display("FAIL wake_vk: got %0h want 3", disp_Vk); end
    checks++; if (disp_dest !== 3'd1) begin errors++; $display("FAIL wake_dest: got %0d want 1", disp_dest); end
    tick();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL wake_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_bypass();
    fu_ready = 1'b1;
    drive_issue(4'b1001, 16'd9, 1'b1, 3'd0, 16'd0, 1'b0, 3'd6, 3'd3);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h1234;
    tick();
    idle();
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL bypass_dv: got %0h want 1", disp_valid); end
    checks++; if (disp_Vk !== 16'h1234) begin errors++; $display("FAIL bypass_vk: got %0h want 1234", disp_Vk); end
    checks++; if (disp_Vj !== 16'd9) begin errors++; $display("FAIL bypass_vj: got %0h want 9", disp_Vj); end
    tick();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL bypass_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_full_backpressure();
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(4'(i + 1), 16'(10 + i), 1'b1, 3'd0, 16'(20 + i), 1'b1, 3'd0, 3'(i));
      tick();
      checks++; if (occupancy !== 3'(i + 1)) begin errors++; $display("FAIL bp_fill_occ%0d: got %0d want %0d", i, occupancy, i + 1); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp_full: got %0h want 1", full); end
    checks++; if (disp_dest !== 3'd0 || disp_Vj !== 16'd10) begin errors++; $display("FAIL bp_head: got dest %0d vj %0d want dest 0 vj 10", disp_dest, disp_Vj); end
    drive_issue(4'hF, 16'hFFFF, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd7);
    tick();
    idle();
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_5th_occ: got %0d want 4", occupancy); end
    checks++; if (disp_dest !== 3'd0 || disp_op !== 4'd1 || disp_Vk !== 16'd20) begin errors++; $display("FAIL bp_stable: got dest %0d op %0h vk %0d want 0 1 20", disp_dest, disp_op, disp_Vk); end
    fu_ready = 1'b1;
    tick();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL bp_unfull: got %0h want 0", full); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (disp_valid !== 1'b1 || disp_dest !== 3'(i) || disp_Vj !== 16'(10 + i)) begin errors++; $display("FAIL bp_drain%0d: got dv %0h dest %0d vj %0d want 1 %0d %0d", i, disp_valid, disp_dest, disp_Vj, i, 10 + i); end
      checks++; if (occupancy !== 3'(4 - i)) begin errors++; $display("FAIL bp_drain_occ%0d: got %0d want %0d", i, occupancy, 4 - i); end
      tick();
    end
    checks++; if (occupancy !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got occ %0d dv %0h want 0 0", occupancy, disp_valid); end
  endtask

  task automatic test_back_to_back();
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(4'd3, 16'(i), 1'b1, 3'd0, 16'd0, 1'b1, 3'd0, 3'(i));
      tick();
    end
    fu_ready = 1'b1;
    drive_issue(4'd7, 16'h0050, 1'b1, 3'd0, 16'h0051, 1'b1, 3'd0, 3'd5);
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %0h want 1", full); end
    tick();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL b2b_refused_occ: got %0d want 3", occupancy); end
    checks++; if (disp_dest !== 3'd1) begin errors++; $display("FAIL b2b_next: got %0d want 1", disp_dest); end
    tick();
    idle();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL b2b_net0_occ: got %0d want 3", occupancy); end
    checks++; if (disp_dest !== 3'd5 || disp_Vj !== 16'h0050 || disp_op !== 4'd7) begin errors++; $display("FAIL b2b_lowest: got dest %0d vj %0h op %0h want 5 50 7", disp_dest, disp_Vj, disp_op); end
    tick();
    checks++; if (occupancy !== 3'd2 || disp_dest !== 3'd2) begin errors++; $display("FAIL b2b_after: got occ %0d dest %0d want 2 2", occupancy, disp_dest); end
    tick();
    tick();
    checks++; if (occupancy !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got occ %0d dv %0h want 0 0", occupancy, disp_valid); end
  endtask

  task automatic test_flush();
    fu_ready = 1'b0;
    drive_issue(4'd2, 16'd0, 1'b0, 3'd3, 16'd1, 1'b1, 3'd0, 3'd1);
    tick();
    drive_issue(4'd2, 16'd0, 1'b0, 3'd3, 16'd2, 1'b1, 3'd0, 3'd2);
    tick();
    checks++; if (occupancy !== 3'd2 || disp_valid !== 1'b0) begin errors++; $display("FAIL flush_pre: got occ %0d dv %0h want 2 0", occupancy, disp_valid); end
    flush = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'hBEEF;
    drive_issue(4'd6, 16'd4, 1'b1, 3'd0, 16'd4, 1'b1, 3'd0, 3'd6);
    tick();
    idle();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL flush_dv: got %0h want 0", disp_valid); end
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h0101;
    tick();
    idle();
    checks++; if (disp_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL flush_stale: got dv %0h occ %0d want 0 0", disp_valid, occupancy); end
    drive_issue(4'd8, 16'h0011, 1'b1, 3'd0, 16'h0022, 1'b1, 3'd0, 3'd4);
    tick();
    idle();
    checks++; if (disp_dest !== 3'd4 || disp_Vj !== 16'h0011 || occupancy !== 3'd1) begin errors++; $display("FAIL flush_reuse: got dest %0d vj %0h occ %0d want 4 11 1", disp_dest, disp_Vj, occupancy); end
    fu_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(4'd1, 16'(i + 1), 1'b1, 3'd0, 16'd1, 1'b1, 3'd0, 3'(i));
      tick();
    end
    idle();
    checks++; if (occupancy !== 3'd3 || disp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got occ %0d dv %0h want 3 1", occupancy, disp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %0h want 0", full); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dv: got %0h want 0", disp_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rstmid_occ: got %0d want 0", occupancy); end
    checks++; if ({disp_op, disp_Vj, disp_Vk, disp_dest} !== 39'd0) begin errors++; $display("FAIL rstmid_disp: got %0h want 0", {disp_op, disp_Vj, disp_Vk, disp_dest}); end
    rst_n = 1'b1;
    tick();
    checks++; if (occupancy !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post: got occ %0d dv %0h want 0 0", occupancy, disp_valid); end
  endtask

  initial begin
    rst_n    = 1'b1;
    fu_ready = 1'b0;
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_full_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Controller for a bank of reservation-station entries in front of one functional unit of the out-of-order LC-3b core.
- Allocates a free entry on issue and snoops the common data bus (CDB) to wake up pending operands.
- Selects one ready entry per cycle and dispatches it to the functional unit.
- Releases the entry on dispatch. A flush clears every entry on a branch mispredict.

Parameters:
num_entries, 4, number of reservation-station entries (power of 2, 2..8)
data_width, 16, operand width
tag_width, 3, ROB tag width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries
issue_valid  input  1  issue request this cycle
issue_op  input  4  lc3b_opcode of the issued instruction
issue_Vj  input  data_width  operand j value
issue_Vj_valid  input  1  operand j value is valid
issue_Qj  input  tag_width  producer tag for operand j
issue_Vk  input  data_width  operand k value
issue_Vk_valid  input  1  operand k value is valid
issue_Qk  input  tag_width  producer tag for operand k
issue_dest  input  tag_width  destination ROB tag
full  output  1  no free entry; issue is refused
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  tag_width  CDB broadcast tag
cdb_data  input  data_width  CDB broadcast value
fu_ready  input  1  functional unit accepts an operation
disp_valid  output  1  a ready entry is presented
disp_op  output  4  opcode of the presented entry
disp_Vj  output  data_width  operand j of the presented entry
disp_Vk  output  data_width  operand k of the presented entry
disp_dest  output  tag_width  destination tag of the presented entry
occupancy  output  clog2(num_entries)+1  count of busy entries

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset (rst_n=0, immediate): every entry's busy, Vj_valid, Vk_valid, op, V, Q and dest are cleared. Outputs become full=0, disp_valid=0, disp_op/Vj/Vk/dest=0, occupancy=0.
- Flush: synchronous, priority over all other events in the same cycle. Clears all entries as reset does. Issue, wakeup and dispatch in the flush cycle are discarded.
- Entry state: busy, op, Vj, Vj_valid, Qj, Vk, Vk_valid, Qk, dest, all registered.
- Entry ready: busy & Vj_valid & Vk_valid, taken from registered state only.
- Allocation:
  - full = all entries busy (combinational from registered busy).
  - When issue_valid & !full, the lowest-index non-busy entry is written at the next edge with busy=1.
  - issue_valid while full is ignored, with no state change. The issuer must hold the request.
- Issue-cycle bypass: if cdb_valid and an issued operand has valid=0 and Q==cdb_tag, the entry captures cdb_data with valid=1 at allocation.
- Wakeup: each busy entry whose operand has valid=0 and Q==cdb_tag while cdb_valid captures cdb_data and sets valid=1 at the next edge.
  - Both operands may wake in the same cycle.
  - An operand that is already valid is never overwritten.
  - A woken entry becomes ready one cycle after the CDB broadcast.
- Select: combinational; the lowest-index ready entry drives disp_*. disp_valid = any entry ready. When disp_valid=0, disp_* hold 0.
- Dispatch handshake:
  - A dispatch occurs when disp_valid & fu_ready.
  - The selected entry is cleared (busy=0, valid bits=0) at that edge.
  - disp_* must stay stable while disp_valid=1 and fu_ready=0, unless a lower-index entry becomes ready.
- Simultaneous issue and dispatch: the slot freed by the dispatch is not visible to allocation until the next cycle, because full and allocation use pre-edge busy. Both events complete in the same cycle.
- occupancy: registered popcount of busy, updated each edge as +1 issue, -1 dispatch, net 0 when both occur.
- Latency: issue with both operands valid -> disp_valid asserted 1 cycle later. Minimum issue-to-dispatch latency is 1 cycle.

Test Plan:
- Reset mid-operation: 3 entries busy, drop rst_n -> full=0, disp_valid=0 and occupancy=0 immediately, without waiting for a clock edge.
- Ready issue: issue op=ADD(0001), Vj=5, Vk=7, both valid, dest=2, fu_ready=1 -> next cycle disp_valid=1, disp_Vj=5, disp_Vk=7, disp_dest=2; after the following edge occupancy=0.
- Wakeup: issue with Qj=4 invalid and Vk=3 valid; two cycles later cdb_valid=1, cdb_tag=4, cdb_data=0x00AA -> disp_valid=1 the cycle after, with disp_Vj=0x00AA. A broadcast of tag 5 causes no wakeup.
- Issue-cycle bypass: issue Qk=6 invalid in the same cycle as cdb_tag=6, cdb_data=0x1234 -> entry ready next cycle with disp_Vk=0x1234.
- Full and backpressure: fu_ready=0, issue 4 ready ops -> full=1 and occupancy=4. A 5th issue is ignored. disp_* show entry 0 stably. Raise fu_ready -> entries 0, 1, 2, 3 dispatch on consecutive cycles. full=0 one cycle after the first dispatch.
- Flush: 2 entries pending with a CDB match and an issue in the same cycle as flush=1 -> next cycle occupancy=0 and disp_valid=0, and no entry is allocated.
